// File: rtl/axil_cmd_master.sv
// Command-to-AXI4-Lite master bridge: one outstanding read or write at a time,
// result returned on a valid/ready response port with a saturating error count.
`timescale 1ns/1ps
module axil_cmd_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH/8
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [1:0]            cmd_op,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [DATA_WIDTH-1:0] cmd_wdata,
   input  logic [STRB_WIDTH-1:0] cmd_wstrb,
   input  logic [2:0]            cmd_prot,

   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [1:0]            rsp_op,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic [1:0]            rsp_resp,
   output logic [7:0]            err_cnt,

   output logic [ADDR_WIDTH-1:0] s_axil_awaddr,
   output logic [2:0]            s_axil_awprot,
   output logic                  s_axil_awvalid,
   input  logic                  s_axil_awready,

   output logic [DATA_WIDTH-1:0] s_axil_wdata,
   output logic [STRB_WIDTH-1:0] s_axil_wstrb,
   output logic                  s_axil_wvalid,
   input  logic                  s_axil_wready,

   input  logic [1:0]            s_axil_bresp,
   input  logic                  s_axil_bvalid,
   output logic                  s_axil_bready,

   output logic [ADDR_WIDTH-1:0] s_axil_araddr,
   output logic [2:0]            s_axil_arprot,
   output logic                  s_axil_arvalid,
   input  logic                  s_axil_arready,

   input  logic [DATA_WIDTH-1:0] s_axil_rdata,
   input  logic [1:0]            s_axil_rresp,
   input  logic                  s_axil_rvalid,
   output logic                  s_axil_rready
);

   // state   | meaning
   // IDLE    | cmd_ready high, waiting for a command
   // WRITE   | AW and W valids up, each drops on its own handshake
   // WR_RESP | both write handshakes done, waiting for B
   // RD_ADDR | arvalid up, waiting for AR handshake
   // RD_DATA | rready up, waiting for R
   // RESP    | rsp_valid up, waiting for rsp_ready
   typedef enum logic [2:0] {
      IDLE, WRITE, WR_RESP, RD_ADDR, RD_DATA, RESP
   } state_t;

   state_t     state;
   logic       aw_done;
   logic       w_done;
   logic [7:0] err_inc;

   // A channel counts as done if it already handshook or handshakes this cycle.
   assign aw_done = !s_axil_awvalid || s_axil_awready;
   assign w_done  = !s_axil_wvalid  || s_axil_wready;
   assign err_inc = (err_cnt == 8'hff) ? err_cnt : err_cnt + 8'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         cmd_ready      <= 1'b0;
         rsp_valid      <= 1'b0;
         rsp_op         <= '0;
         rsp_data       <= '0;
         rsp_resp       <= '0;
         err_cnt        <= '0;
         s_axil_awaddr  <= '0;
         s_axil_awprot  <= '0;
         s_axil_awvalid <= 1'b0;
         s_axil_wdata   <= '0;
         s_axil_wstrb   <= '0;
         s_axil_wvalid  <= 1'b0;
         s_axil_bready  <= 1'b0;
         s_axil_araddr  <= '0;
         s_axil_arprot  <= '0;
         s_axil_arvalid <= 1'b0;
         s_axil_rready  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (cmd_valid && cmd_ready) begin
                  cmd_ready <= 1'b0;
                  rsp_op    <= cmd_op;
                  case (cmd_op)
                     2'b01: begin
                        s_axil_awaddr  <= cmd_addr;
                        s_axil_awprot  <= cmd_prot;
                        s_axil_wdata   <= cmd_wdata;
                        s_axil_wstrb   <= cmd_wstrb;
                        s_axil_awvalid <= 1'b1;
                        s_axil_wvalid  <= 1'b1;
                        s_axil_bready  <= 1'b1;
                        state          <= WRITE;
                     end
                     2'b10: begin
                        s_axil_araddr  <= cmd_addr;
                        s_axil_arprot  <= cmd_prot;
                        s_axil_arvalid <= 1'b1;
                        state          <= RD_ADDR;
                     end
                     default: begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= '0;
                        rsp_resp  <= 2'b10;
                        err_cnt   <= err_inc;
                        state     <= RESP;
                     end
                  endcase
               end else begin
                  cmd_ready <= 1'b1;
               end
            end
            WRITE: begin
               if (s_axil_awvalid && s_axil_awready) s_axil_awvalid <= 1'b0;
               if (s_axil_wvalid && s_axil_wready)   s_axil_wvalid  <= 1'b0;
               if (aw_done && w_done) state <= WR_RESP;
            end
            WR_RESP: begin
               if (s_axil_bvalid) begin
                  s_axil_bready <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_data      <= '0;
                  rsp_resp      <= s_axil_bresp;
                  if (s_axil_bresp != 2'b00) err_cnt <= err_inc;
                  state         <= RESP;
               end
            end
            RD_ADDR: begin
               if (s_axil_arready) begin
                  s_axil_arvalid <= 1'b0;
                  s_axil_rready  <= 1'b1;
                  state          <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (s_axil_rvalid) begin
                  s_axil_rready <= 1'b0;
                  rsp_valid     <= 1'b1;
                  rsp_data      <= s_axil_rdata;
                  rsp_resp      <= s_axil_rresp;
                  if (s_axil_rresp != 2'b00) err_cnt <= err_inc;
                  state         <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  cmd_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Directed bench for axil_cmd_master: slave channels driven by hand-timed
// vectors, outputs sampled on the falling edge against hand-computed values.
`timescale 1ns/1ps
module tb_axil_cmd_master;

   logic        clk;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic [2:0]  cmd_prot;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [1:0]  rsp_op;
   logic [31:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic [7:0]  err_cnt;
   logic [31:0] awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [31:0] araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;

   int n_vec  = 0;
   int n_miss = 0;

   axil_cmd_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .STRB_WIDTH(4)) dut (
      .clk            (clk),
      .rst            (rst),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_op         (cmd_op),
      .cmd_addr       (cmd_addr),
      .cmd_wdata      (cmd_wdata),
      .cmd_wstrb      (cmd_wstrb),
      .cmd_prot       (cmd_prot),
      .rsp_valid      (rsp_valid),
      .rsp_ready      (rsp_ready),
      .rsp_op         (rsp_op),
      .rsp_data       (rsp_data),
      .rsp_resp       (rsp_resp),
      .err_cnt        (err_cnt),
      .s_axil_awaddr  (awaddr),
      .s_axil_awprot  (awprot),
      .s_axil_awvalid (awvalid),
      .s_axil_awready (awready),
      .s_axil_wdata   (wdata),
      .s_axil_wstrb   (wstrb),
      .s_axil_wvalid  (wvalid),
      .s_axil_wready  (wready),
      .s_axil_bresp   (bresp),
      .s_axil_bvalid  (bvalid),
      .s_axil_bready  (bready),
      .s_axil_araddr  (araddr),
      .s_axil_arprot  (arprot),
      .s_axil_arvalid (arvalid),
      .s_axil_arready (arready),
      .s_axil_rdata   (rdata),
      .s_axil_rresp   (rresp),
      .s_axil_rvalid  (rvalid),
      .s_axil_rready  (rready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, want finish before 1ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_cmd(input logic [1:0] op, input logic [31:0] addr,
                            input logic [31:0] data, input logic [3:0] strb,
                            input logic [2:0] prot);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = addr;
      cmd_wdata = data;
      cmd_wstrb = strb;
      cmd_prot  = prot;
   endtask

   // Zero-wait write; returns on the falling edge where the response is visible.
   task automatic write_fast(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] resp);
      awready = 1'b1;
      wready  = 1'b1;
      drive_cmd(2'b01, addr, data, 4'hf, 3'b000);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      bvalid = 1'b1;
      bresp  = resp;
      @(negedge clk);
      bvalid    = 1'b0;
      rsp_ready = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_wdata = '0;
      cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; bresp = '0; bvalid = 1'b0;
      arready = 1'b0; rdata = '0; rresp = '0; rvalid = 1'b0;

      // reset state
      #12;
      check_val("rst_cmd_ready", cmd_ready, 0);
      check_val("rst_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 0);
      check_val("rst_err_cnt", err_cnt, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("post_rst_cmd_ready", cmd_ready, 1);

      // zero-wait write
      awready = 1'b1; wready = 1'b1;
      drive_cmd(2'b01, 32'h10, 32'hdeadbeef, 4'hf, 3'b010);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("w1_cmd_ready", cmd_ready, 0);
      check_val("w1_aw_w_valid", {awvalid, wvalid, bready}, 3'b111);
      check_val("w1_awaddr", awaddr, 32'h10);
      check_val("w1_wdata", wdata, 32'hdeadbeef);
      check_val("w1_wstrb", wstrb, 4'hf);
      check_val("w1_awprot", awprot, 3'b010);
      @(negedge clk);
      check_val("w1_valids_drop", {awvalid, wvalid, bready, rsp_valid}, 4'b0010);
      bvalid = 1'b1; bresp = 2'b00;
      @(negedge clk);
      check_val("w1_rsp_valid", rsp_valid, 1);
      check_val("w1_rsp", {rsp_op, rsp_resp, rsp_data}, {2'b01, 2'b00, 32'h0});
      check_val("w1_err_cnt", err_cnt, 0);
      check_val("w1_bready", bready, 0);
      bvalid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      check_val("w1_done", {rsp_valid, cmd_ready}, 2'b01);
      rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0;

      // write with wready delayed to N+4
      awready = 1'b1;
      drive_cmd(2'b01, 32'h44, 32'ha5a50f0f, 4'h3, 3'b000);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("w2_n0_valids", {awvalid, wvalid}, 2'b11);
      @(negedge clk);
      check_val("w2_n1_valids", {awvalid, wvalid}, 2'b01);
      check_val("w2_n1_wdata", wdata, 32'ha5a50f0f);
      @(negedge clk);
      check_val("w2_n2_valids", {awvalid, wvalid}, 2'b01);
      check_val("w2_n2_wstrb", wstrb, 4'h3);
      @(negedge clk);
      check_val("w2_n3_wvalid", wvalid, 1);
      check_val("w2_n3_wdata", wdata, 32'ha5a50f0f);
      wready = 1'b1;
      @(negedge clk);
      check_val("w2_n4_state", {wvalid, bready, rsp_valid}, 3'b010);
      bvalid = 1'b1; bresp = 2'b00;
      @(negedge clk);
      check_val("w2_rsp_valid", {rsp_valid, bready, rsp_resp}, {1'b1, 1'b0, 2'b00});
      @(negedge clk);
      check_val("w2_stray_b", {rsp_valid, bready, err_cnt}, {1'b1, 1'b0, 8'd0});
      bvalid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      check_val("w2_consumed", {rsp_valid, cmd_ready}, 2'b01);
      rsp_ready = 1'b0; awready = 1'b0; wready = 1'b0;
      @(negedge clk);
      check_val("w2_single_rsp", rsp_valid, 0);

      // read with rvalid at N+3, then rsp_ready held off 5 cycles
      arready = 1'b1;
      drive_cmd(2'b10, 32'h20, 32'h0, 4'h0, 3'b001);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("r1_arvalid", {arvalid, awvalid, wvalid, cmd_ready}, 4'b1000);
      check_val("r1_araddr", araddr, 32'h20);
      check_val("r1_arprot", arprot, 3'b001);
      @(negedge clk);
      check_val("r1_ar_done", {arvalid, rready}, 2'b01);
      @(negedge clk);
      check_val("r1_wait", {rready, rsp_valid}, 2'b10);
      rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
      @(negedge clk);
      check_val("r1_rsp_valid", {rsp_valid, rready}, 2'b10);
      check_val("r1_rsp", {rsp_op, rsp_resp, rsp_data}, {2'b10, 2'b00, 32'h12345678});
      rvalid = 1'b0; rdata = 32'h0; arready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_val("hold_rsp", {rsp_valid, rsp_op, rsp_resp, rsp_data},
                   {1'b1, 2'b10, 2'b00, 32'h12345678});
         check_val("hold_quiet", {cmd_ready, awvalid, wvalid, arvalid}, 4'b0000);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      check_val("hold_release", {rsp_valid, cmd_ready}, 2'b01);
      rsp_ready = 1'b0;

      // reserved ops
      drive_cmd(2'b11, 32'h80, 32'h0, 4'h0, 3'b000);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("op11_rsp", {rsp_valid, rsp_op, rsp_resp, rsp_data}, {1'b1, 2'b11, 2'b10, 32'h0});
      check_val("op11_no_bus", {awvalid, wvalid, arvalid, bready, rready}, 0);
      check_val("op11_err_cnt", err_cnt, 1);
      rsp_ready = 1'b1;
      @(negedge clk);
      check_val("op11_done", cmd_ready, 1);
      rsp_ready = 1'b0;
      drive_cmd(2'b00, 32'h84, 32'h0, 4'h0, 3'b000);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("op00_rsp", {rsp_valid, rsp_op, rsp_resp}, {1'b1, 2'b00, 2'b10});
      check_val("op00_err_cnt", err_cnt, 2);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // 300 SLVERR writes: count saturates at 255
      for (int i = 1; i <= 300; i++) begin
         write_fast(32'h100 + 32'(i), 32'(i), 2'b10);
         check_val("sat_err_cnt", err_cnt, (2 + i > 255) ? 255 : 2 + i);
         if (i == 1) check_val("sat_rsp_resp", rsp_resp, 2'b10);
         @(negedge clk);
         rsp_ready = 1'b0;
      end
      awready = 1'b0; wready = 1'b0;

      // asynchronous reset mid-read
      drive_cmd(2'b10, 32'h30, 32'h0, 4'h0, 3'b000);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("rr_arvalid", arvalid, 1);
      #2 rst = 1'b0;
      #1;
      check_val("rr_valids", {awvalid, wvalid, arvalid, bready, rready, rsp_valid, cmd_ready}, 0);
      check_val("rr_err_cnt", err_cnt, 0);
      check_val("rr_araddr", araddr, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_val("rr_cmd_ready", cmd_ready, 1);
      arready = 1'b1;
      drive_cmd(2'b10, 32'h34, 32'h0, 4'h0, 3'b000);
      @(negedge clk);
      cmd_valid = 1'b0;
      check_val("rr2_arvalid", {arvalid, araddr}, {1'b1, 32'h34});
      @(negedge clk);
      rvalid = 1'b1; rdata = 32'hcafef00d; rresp = 2'b00;
      @(negedge clk);
      check_val("rr2_rsp", {rsp_valid, rsp_op, rsp_resp, rsp_data}, {1'b1, 2'b10, 2'b00, 32'hcafef00d});
      check_val("rr2_err_cnt", err_cnt, 0);
      rvalid = 1'b0; rsp_ready = 1'b1;
      @(negedge clk);
      check_val("rr2_done", {rsp_valid, cmd_ready}, 2'b01);
      rsp_ready = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
